fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO; the next-generation buffer for byte/word streams between producer and consumer logic in the same clock domain. It generalises data width and depth, and sizes its occupancy counter correctly so that a full FIFO is representable. It adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a read-data-valid strobe and an optional first-word-fall-through (FWFT) read mode.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 64, number of entries; power of two, ≥4
- AF_THRESH, DEPTH-4, almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH
- AE_THRESH, 4, almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- Derived: AW = log2(DEPTH), CW = AW+1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- buf_in  in  DATA_W  write data
- rd_en  in  1  read request (acknowledge of head word in FWFT mode)
- err_clr  in  1  clears overflow/underflow sticky flags
- buf_out  out  DATA_W  read data
- rd_valid  out  1  buf_out carries valid read data
- buf_empty  out  1  count == 0
- buf_full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_THRESH
- almost_full  out  1  count ≥ AF_THRESH
- fifo_counter  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH × DATA_W array. The array is not reset. Pointers wr_ptr and rd_ptr are AW bits wide and wrap naturally from DEPTH-1 to 0.
- Accepted write: wr_acc = wr_en & !buf_full. It stores buf_in at wr_ptr and increments wr_ptr.
- Accepted read: rd_acc = rd_en & !buf_empty. It increments rd_ptr.
- Flags gate on the current (pre-edge) state:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Counter updates:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both: unchanged.
  - Neither: unchanged.
  - The counter never exceeds DEPTH and never goes below 0.
- Flags are pure decodes of the registered fifo_counter (no combinational path from inputs).
- Error flags:
  - overflow sets on wr_en & buf_full.
  - underflow sets on rd_en & buf_empty.
  - Both hold until err_clr or rst. If set and clear occur in the same cycle, set wins.
  - Rejected operations change no other state.
- Standard mode (FWFT=0):
  - On rd_acc, buf_out <= mem[rd_ptr] and rd_valid <= 1 on the same edge. Otherwise rd_valid <= 0 and buf_out holds.
- FWFT mode (FWFT=1):
  - buf_out = mem[rd_ptr] (combinational from array and pointer); rd_valid = !buf_empty.
  - rd_en pops the head. The next word appears on buf_out after that same edge.
  - buf_out is don't-care while empty.
- Reset (rst high at an edge, any time, including mid-burst) sets:
  - fifo_counter=0, wr_ptr=0, rd_ptr=0.
  - buf_out=0 (standard mode), rd_valid=0.
  - buf_empty=1, buf_full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - Reset overrides wr_en and rd_en in that cycle. All previously stored data is discarded.

## Timing
- Write latency: data written at edge N is readable from edge N+1 onward.
- Flags and fifo_counter reflect all operations accepted at edge N from just after edge N.
- Standard read latency: rd_en high before edge N gives buf_out valid and rd_valid=1 from just after edge N until edge N+1.
- FWFT first-word latency: a write into an empty FIFO at edge N gives buf_empty=0, rd_valid=1 and buf_out equal to that word after edge N.
- Full throughput: one write and one read per cycle are sustained indefinitely when 0 < count < DEPTH.

## Test plan
- Fill (DATA_W=8, DEPTH=16): write 0x00..0x0F on consecutive cycles.
  - Required: after the 16th edge, fifo_counter=16 and buf_full=1.
  - almost_full rises when count reaches 12.
  - A 17th write leaves count at 16 and sets overflow=1.
- Drain: read 16 times.
  - Required: buf_out sequence is 0x00..0x0F, with rd_valid high one cycle after each rd_en.
  - buf_empty=1 and almost_empty=1 at the end.
  - A further rd_en sets underflow=1, leaves buf_out at 0x0F, and err_clr clears the flag.
- Simultaneous traffic: at count=5, assert rd_en and wr_en together for 20 cycles.
  - Required: count stays 5 and output order is strict FIFO.
  - Also: simultaneous rd_en/wr_en when full gives count 15 with the write rejected; when empty, count 1 with the read rejected.
- Wrap-around: 4 rounds of write 12 then read 12 with incrementing data.
  - Required: pointers wrap past 15 and all 48 words come out in order.
- Reset mid-operation: at count=7 with wr_en=1, assert rst for one edge.
  - Required: every output at its reset value after that edge; the next write/read pair returns the new word, not stale data.
- FWFT=1: write 0xA5 into an empty FIFO.
  - Required: buf_out=0xA5 and rd_valid=1 one edge later with no rd_en.
  - One rd_en cycle then returns buf_empty=1.

Source files
------------

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with thresholds, sticky errors and optional FWFT read
// Inputs:  clk, rst (sync, active-high), wr_en/buf_in, rd_en, err_clr
// Outputs: buf_out/rd_valid, buf_empty, buf_full, almost_empty, almost_full,
//          fifo_counter (0..DEPTH), overflow/underflow (sticky)
module fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AF_THRESH = DEPTH - 4,
  parameter int unsigned AE_THRESH = 4,
  parameter bit          FWFT      = 1'b0,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] buf_out,
  output logic              rd_valid,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CW-1:0]     fifo_counter,
  output logic              overflow,
  output logic              underflow
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc   = wr_en & ~buf_full;
    rd_acc   = rd_en & ~buf_empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = (wr_acc & ~rd_acc) ? cnt_q + 1'b1 : (rd_acc & ~wr_acc) ? cnt_q - 1'b1 : cnt_q;
    ovf_d    = (wr_en & buf_full) | (ovf_q & ~err_clr);
    unf_d    = (rd_en & buf_empty) | (unf_q & ~err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= buf_in;
  end
  assign buf_empty    = cnt_q == '0;
  assign buf_full     = cnt_q == CW'(DEPTH);
  assign almost_empty = cnt_q <= CW'(AE_THRESH);
  assign almost_full  = cnt_q >= CW'(AF_THRESH);
  assign fifo_counter = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  if (FWFT) begin : g_fwft
    assign buf_out  = mem_q[rd_ptr_q];
    assign rd_valid = ~buf_empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;
    logic vld_q;
    always_comb dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        dout_q <= dout_d;
        vld_q  <= rd_acc;
      end
    end
    assign buf_out  = dout_q;
    assign rd_valid = vld_q;
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench for fifo_param in standard and FWFT modes
module tb_fifo_param;
  logic clk = 1'b0;
  logic rst, wr_en, rd_en, err_clr;
  logic [7:0] buf_in, buf_out;
  logic rd_valid, buf_empty, buf_full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] fifo_counter;
  logic f_wr_en, f_rd_en;
  logic [7:0] f_buf_in, f_buf_out;
  logic f_rd_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [4:0] f_cnt;
  int errors = 0;
  int checks = 0;
  logic [7:0] q [$];
  int m_cnt;
  logic [7:0] m_out;
  logic m_ovf, m_unf;
  always #5 clk = ~clk;
  fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en), .err_clr(err_clr),
    .buf_out(buf_out), .rd_valid(rd_valid), .buf_empty(buf_empty), .buf_full(buf_full),
    .almost_empty(almost_empty), .almost_full(almost_full), .fifo_counter(fifo_counter),
    .overflow(overflow), .underflow(underflow)
  );
  fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .buf_in(f_buf_in), .rd_en(f_rd_en), .err_clr(1'b0),
    .buf_out(f_buf_out), .rd_valid(f_rd_valid), .buf_empty(f_empty), .buf_full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .fifo_counter(f_cnt),
    .overflow(f_ovf), .underflow(f_unf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c, input logic rs);
    logic wa, ra;
    wr_en = w; rd_en = r; buf_in = d; err_clr = c; rst = rs;
    wa = w && m_cnt != 16;
    ra = r && m_cnt != 0;
    if (rs) begin
      q.delete();
      m_cnt = 0; m_out = 8'h00; m_ovf = 1'b0; m_unf = 1'b0; ra = 1'b0;
    end else begin
      m_ovf = (w && m_cnt == 16) || (m_ovf && !c);
      m_unf = (r && m_cnt == 0) || (m_unf && !c);
      if (wa) q.push_back(d);
      m_cnt = m_cnt + int'(wa) - int'(ra);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'(ra));
    if (rd_valid === 1'b1 && q.size() > 0) m_out = q.pop_front();
    chk("buf_out", 32'(buf_out), 32'(m_out));
    chk("fifo_counter", 32'(fifo_counter), 32'(m_cnt));
    chk("buf_empty", 32'(buf_empty), 32'(m_cnt == 0));
    chk("buf_full", 32'(buf_full), 32'(m_cnt == 16));
    chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 4));
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= 12));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask
  initial begin
    logic [7:0] v;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; buf_in = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_buf_in = 8'h00;
    m_cnt = 0; m_out = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    cyc(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0, 0);
    chk("full_after_fill", 32'(buf_full), 32'd1);
    cyc(1, 0, 8'hEE, 0, 0);
    chk("overflow_17th", 32'(overflow), 32'd1);
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 0, 0);
    chk("drain_last", 32'(buf_out), 32'h0F);
    cyc(0, 1, 8'h00, 0, 0);
    chk("underflow_set", 32'(underflow), 32'd1);
    chk("buf_out_hold", 32'(buf_out), 32'h0F);
    cyc(0, 0, 8'h00, 1, 0);
    chk("underflow_clr", 32'(underflow), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'(8'h30 + i), 0, 0);
    chk("count_stays_5", 32'(fifo_counter), 32'd5);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h60 + i), 0, 0);
    cyc(1, 1, 8'hDD, 0, 0);
    chk("full_rw_count", 32'(fifo_counter), 32'd15);
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h77, 0, 0);
    chk("empty_rw_count", 32'(fifo_counter), 32'd1);
    cyc(0, 1, 8'h00, 1, 0);
    chk("empty_rw_word", 32'(buf_out), 32'h77);
    v = 8'h80;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 12; i++) begin cyc(1, 0, v, 0, 0); v = v + 8'd1; end
      for (int i = 0; i < 12; i++) cyc(0, 1, 8'h00, 0, 0);
    end
    chk("wrap_last", 32'(buf_out), 32'(v - 8'd1));
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
    cyc(1, 0, 8'hCF, 0, 1);
    chk("rst_mid_count", 32'(fifo_counter), 32'd0);
    chk("rst_mid_out", 32'(buf_out), 32'd0);
    cyc(1, 0, 8'h99, 0, 0);
    cyc(0, 1, 8'h00, 0, 0);
    chk("post_rst_word", 32'(buf_out), 32'h99);
    chk("q_empty", 32'(q.size()), 32'd0);
    f_wr_en = 1'b1; f_buf_in = 8'hA5;
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    chk("fwft_out", 32'(f_buf_out), 32'hA5);
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_nonempty", 32'(f_empty), 32'd0);
    f_rd_en = 1'b1;
    @(posedge clk);
    #1;
    f_rd_en = 1'b0;
    chk("fwft_empty", 32'(f_empty), 32'd1);
    chk("fwft_valid_low", 32'(f_rd_valid), 32'd0);
    chk("fwft_count", 32'(f_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
